// File: rtl/constants_pkg.sv
// Shared core constants: bus widths, memory access size encodings and arbiter types.
package constants_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  localparam int ARB_MAX_DSTREAK_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational fetch/data pick: data wins unless fetch has waited out a full data streak.
// Zero latency; the caller decides when a pick is acted upon.
module mem_arb_pick #(
  parameter int SW = 3
) (
  input  logic          i_req,
  input  logic          d_req,
  input  logic [SW-1:0] streak,
  input  logic [SW-1:0] max_dstreak,
  output logic          grant_i,
  output logic          grant_d
);

  logic fetch_due;

  assign fetch_due = i_req && (streak == max_dstreak);
  assign grant_d   = d_req && !fetch_due;
  assign grant_i   = i_req && !grant_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data: one outstanding transaction, grant N+1,
// rvalid the cycle after ack; requesters wait on held request lines while the port is busy.
module mem_port_arbiter
  import constants_pkg::*;
#(
  parameter int AWIDTH      = ADDR_WIDTH,
  parameter int DWIDTH      = DATA_WIDTH,
  parameter int MAX_DSTREAK = ARB_MAX_DSTREAK_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_i,
  input  logic [AWIDTH-1:0] i_addr_i,
  output logic              i_gnt_o,
  output logic              i_rvalid_o,
  output logic [DWIDTH-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic              d_we_i,
  input  logic [1:0]        d_size_i,
  input  logic              d_unsigned_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic              m_req_o,
  output logic [AWIDTH-1:0] m_addr_o,
  output logic              m_we_o,
  output logic [1:0]        m_size_o,
  output logic              m_unsigned_o,
  output logic [DWIDTH-1:0] m_wdata_o,
  input  logic              m_ack_i,
  input  logic [DWIDTH-1:0] m_rdata_i,
  output logic              spurious_ack_o
);

  localparam int            SW         = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] streak_q;
  logic          pick_i, pick_d;
  logic          issue_i, issue_d, done_i, done_d, spurious_set;

  mem_arb_pick #(.SW(SW)) u_pick (
    .i_req       (i_req_i),
    .d_req       (d_req_i),
    .streak      (streak_q),
    .max_dstreak (STREAK_MAX),
    .grant_i     (pick_i),
    .grant_d     (pick_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_d)      state_d = BUSY_D;
        else if (pick_i) state_d = BUSY_I;
      end
      BUSY_I, BUSY_D: if (m_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue_i      = 1'b0;
    issue_d      = 1'b0;
    done_i       = 1'b0;
    done_d       = 1'b0;
    spurious_set = 1'b0;
    case (state_q)
      IDLE: begin
        issue_d      = pick_d;
        issue_i      = pick_i;
        spurious_set = m_ack_i;
      end
      BUSY_I:  done_i = m_ack_i;
      BUSY_D:  done_d = m_ack_i;
      default: ;
    endcase
  end

  // The memory request is exactly "a transaction is outstanding", so reset drops it at once.
  assign m_req_o = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_addr_o       <= '0;
      m_we_o         <= 1'b0;
      m_size_o       <= 2'd0;
      m_unsigned_o   <= 1'b0;
      m_wdata_o      <= '0;
      i_gnt_o        <= 1'b0;
      d_gnt_o        <= 1'b0;
      i_rvalid_o     <= 1'b0;
      d_rvalid_o     <= 1'b0;
      i_rdata_o      <= '0;
      d_rdata_o      <= '0;
      streak_q       <= '0;
      spurious_ack_o <= 1'b0;
    end else begin
      i_gnt_o    <= issue_i;
      d_gnt_o    <= issue_d;
      i_rvalid_o <= done_i;
      d_rvalid_o <= done_d;

      if (issue_d) begin
        m_addr_o     <= d_addr_i;
        m_we_o       <= d_we_i;
        m_size_o     <= d_size_i;
        m_unsigned_o <= d_unsigned_i;
        m_wdata_o    <= d_wdata_i;
      end else if (issue_i) begin
        m_addr_o     <= i_addr_i;
        m_we_o       <= 1'b0;
        m_size_o     <= MEM_SIZE_WORD;
        m_unsigned_o <= 1'b1;
        m_wdata_o    <= '0;
      end

      if (done_i) i_rdata_o <= m_rdata_i;
      if (done_d) d_rdata_o <= m_we_o ? '0 : m_rdata_i;

      // Streak only counts data grants that actually made a waiting fetch wait longer.
      if (issue_i) begin
        streak_q <= '0;
      end else if (issue_d) begin
        if (!i_req_i)                  streak_q <= '0;
        else if (streak_q != STREAK_MAX) streak_q <= streak_q + SW'(1);
      end

      if (spurious_set) spurious_ack_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
  import constants_pkg::*;

  localparam logic [7:0] G_D = 8'h44;
  localparam logic [7:0] G_I = 8'h49;
  localparam logic [7:0] G_N = 8'h2d;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_i, i_gnt_o, i_rvalid_o;
  logic [31:0] i_addr_i, i_rdata_o;
  logic        d_req_i, d_we_i, d_unsigned_i, d_gnt_o, d_rvalid_o;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic [1:0]  d_size_i, m_size_o;
  logic        m_req_o, m_we_o, m_unsigned_o, m_ack_i, spurious_ack_o;
  logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .MAX_DSTREAK(4)) dut (
    .clk(clk), .rst(rst),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_we_i(d_we_i), .d_size_i(d_size_i),
    .d_unsigned_i(d_unsigned_i), .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_we_o(m_we_o), .m_size_o(m_size_o),
    .m_unsigned_o(m_unsigned_o), .m_wdata_o(m_wdata_o),
    .m_ack_i(m_ack_i), .m_rdata_i(m_rdata_i), .spurious_ack_o(spurious_ack_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction: raise requests, wait for a grant, drop the granted request, ack at once.
  task automatic txn(input logic ireq, input logic dreq, output logic [7:0] g);
    i_req_i = ireq;
    d_req_i = dreq;
    g = G_N;
    for (int k = 0; k < 10 && g == G_N; k++) begin
      tick();
      if (d_gnt_o) begin
        g = G_D;
        d_req_i = 1'b0;
      end else if (i_gnt_o) begin
        g = G_I;
        i_req_i = 1'b0;
      end
    end
    if (g == G_N) chk("txn_grant_timeout", {31'b0, i_gnt_o | d_gnt_o}, 32'd1);
    m_ack_i = 1'b1;
    tick();
    m_ack_i = 1'b0;
  endtask

  logic [7:0] exp_order [10];
  logic [7:0] g;
  int         n;

  initial begin
    exp_order = '{G_D, G_D, G_D, G_D, G_I, G_D, G_D, G_D, G_D, G_I};
    rst = 1'b1;
    i_req_i = 0; i_addr_i = 0;
    d_req_i = 0; d_addr_i = 0; d_we_i = 0; d_size_i = 0; d_unsigned_i = 0; d_wdata_i = 0;
    m_ack_i = 0; m_rdata_i = 0;
    tick(); tick();
    chk("rst_m_req", {31'b0, m_req_o}, 32'd0);
    chk("rst_gnt", {30'b0, i_gnt_o, d_gnt_o}, 32'd0);
    chk("rst_rvalid", {30'b0, i_rvalid_o, d_rvalid_o}, 32'd0);
    chk("rst_spurious", {31'b0, spurious_ack_o}, 32'd0);
    chk("rst_m_addr", m_addr_o, 32'd0);
    rst = 1'b0;

    // Lone fetch, same-cycle ack.
    i_req_i = 1; i_addr_i = 32'h0100_0000; m_rdata_i = 32'h0000_8067;
    tick();
    chk("f_gnt", {31'b0, i_gnt_o}, 32'd1);
    chk("f_dgnt", {31'b0, d_gnt_o}, 32'd0);
    chk("f_m_req", {31'b0, m_req_o}, 32'd1);
    chk("f_m_addr", m_addr_o, 32'h0100_0000);
    chk("f_m_size", {30'b0, m_size_o}, {30'b0, MEM_SIZE_WORD});
    chk("f_m_unsigned", {31'b0, m_unsigned_o}, 32'd1);
    i_req_i = 0; m_ack_i = 1;
    tick();
    m_ack_i = 0;
    chk("f_rvalid", {31'b0, i_rvalid_o}, 32'd1);
    chk("f_rdata", i_rdata_o, 32'h0000_8067);
    chk("f_m_req_drop", {31'b0, m_req_o}, 32'd0);
    chk("f_gnt_pulse", {31'b0, i_gnt_o}, 32'd0);
    tick();
    chk("f_rvalid_pulse", {31'b0, i_rvalid_o}, 32'd0);
    chk("f_rdata_hold", i_rdata_o, 32'h0000_8067);

    // Store with a 3-cycle ack delay; rdata must read back as zero.
    d_req_i = 1; d_we_i = 1; d_size_i = MEM_SIZE_WORD; d_unsigned_i = 0;
    d_addr_i = 32'h0100_0010; d_wdata_i = 32'hDEAD_BEEF; m_rdata_i = 32'h1234_5678;
    tick();
    chk("sw_gnt", {31'b0, d_gnt_o}, 32'd1);
    chk("sw_m_we", {31'b0, m_we_o}, 32'd1);
    chk("sw_m_wdata", m_wdata_o, 32'hDEAD_BEEF);
    d_req_i = 0; d_wdata_i = 32'h0; d_addr_i = 32'h0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("sw_hold_req%0d", c), {31'b0, m_req_o}, 32'd1);
      chk($sformatf("sw_hold_addr%0d", c), m_addr_o, 32'h0100_0010);
      chk($sformatf("sw_hold_wdata%0d", c), m_wdata_o, 32'hDEAD_BEEF);
      chk($sformatf("sw_no_rvalid%0d", c), {31'b0, d_rvalid_o}, 32'd0);
    end
    m_ack_i = 1;
    tick();
    m_ack_i = 0;
    chk("sw_rvalid", {31'b0, d_rvalid_o}, 32'd1);
    chk("sw_rdata_zero", d_rdata_o, 32'd0);
    chk("sw_m_req_drop", {31'b0, m_req_o}, 32'd0);

    // Signed byte load.
    d_req_i = 1; d_we_i = 0; d_size_i = MEM_SIZE_BYTE; d_unsigned_i = 0;
    d_addr_i = 32'h0100_0013; m_rdata_i = 32'h0000_00AB;
    tick();
    chk("lb_gnt", {31'b0, d_gnt_o}, 32'd1);
    chk("lb_m_size", {30'b0, m_size_o}, {30'b0, MEM_SIZE_BYTE});
    chk("lb_m_unsigned", {31'b0, m_unsigned_o}, 32'd0);
    chk("lb_m_we", {31'b0, m_we_o}, 32'd0);
    chk("lb_m_addr", m_addr_o, 32'h0100_0013);
    d_req_i = 0;
    tick();
    m_ack_i = 1;
    tick();
    m_ack_i = 0;
    chk("lb_rvalid", {31'b0, d_rvalid_o}, 32'd1);
    chk("lb_rdata", d_rdata_o, 32'h0000_00AB);

    // Starvation: both requesters continuous, memory acks immediately.
    i_req_i = 1; d_req_i = 1; i_addr_i = 32'h100; d_addr_i = 32'h200; d_size_i = MEM_SIZE_WORD;
    m_rdata_i = 32'h5555_AAAA;
    n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      tick();
      if (d_gnt_o || i_gnt_o) begin
        g = d_gnt_o ? G_D : G_I;
        chk($sformatf("starve_grant%0d", n), {24'b0, g}, {24'b0, exp_order[n]});
        n++;
      end
      m_ack_i = m_req_o;
    end
    chk("starve_count", n, 32'd10);
    i_req_i = 0; d_req_i = 0;
    tick();
    m_ack_i = 0;
    chk("starve_idle", {31'b0, m_req_o}, 32'd0);

    // Lone fetch after a full data streak clears it, so contention again favours data.
    for (int k = 0; k < 4; k++) begin
      txn(1'b1, 1'b1, g);
      chk($sformatf("clr_d%0d", k), {24'b0, g}, {24'b0, G_D});
    end
    txn(1'b1, 1'b0, g);
    chk("clr_lone_i", {24'b0, g}, {24'b0, G_I});
    txn(1'b1, 1'b1, g);
    chk("clr_first_d", {24'b0, g}, {24'b0, G_D});
    txn(1'b1, 1'b0, g);
    chk("clr_last_i", {24'b0, g}, {24'b0, G_I});

    // Spurious ack while idle.
    tick();
    m_ack_i = 1;
    tick();
    m_ack_i = 0;
    chk("sp_flag", {31'b0, spurious_ack_o}, 32'd1);
    chk("sp_no_rvalid", {30'b0, i_rvalid_o, d_rvalid_o}, 32'd0);
    chk("sp_no_req", {31'b0, m_req_o}, 32'd0);
    tick(); tick();
    chk("sp_sticky", {31'b0, spurious_ack_o}, 32'd1);

    // Reset in BUSY_D abandons the store; a late ack counts as spurious.
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h0100_0020; d_wdata_i = 32'hCAFE_F00D;
    tick();
    chk("rb_gnt", {31'b0, d_gnt_o}, 32'd1);
    d_req_i = 0;
    tick();
    rst = 1;
    #1;
    chk("rb_m_req", {31'b0, m_req_o}, 32'd0);
    chk("rb_m_addr", m_addr_o, 32'd0);
    chk("rb_m_wdata", m_wdata_o, 32'd0);
    chk("rb_spurious", {31'b0, spurious_ack_o}, 32'd0);
    chk("rb_rdata", i_rdata_o | d_rdata_o, 32'd0);
    tick();
    rst = 0;
    tick();
    m_ack_i = 1;
    tick();
    m_ack_i = 0;
    chk("rb_no_rvalid", {31'b0, d_rvalid_o}, 32'd0);
    chk("rb_late_ack_spurious", {31'b0, spurious_ack_o}, 32'd1);
    chk("rb_idle", {31'b0, m_req_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
